// File: rtl/mem_access_unit.sv
// mem_access_unit: one-outstanding data-memory access controller with pipeline stall, byte lanes and LBU zero-extension.
// Define MEM_ALIGN_CHECK_EN to complete misaligned word accesses without a memory request and pulse misaligned_o.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              op_valid_i,
    input  logic              is_load_op_i,
    input  logic              is_store_op_i,
    input  logic              is_byte_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [31:0]       req_wdata_o,
    output logic [3:0]        req_be_o,
    input  logic              resp_valid_i,
    input  logic [31:0]       resp_rdata_i,
    output logic              misaligned_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic start, mis_now, is_byte, mis, capture;
    logic [1:0] lane;
    logic [31:0] rdata;
    logic [7:0] rbyte;

    assign start = op_valid_i & (is_store_op_i | is_load_op_i);
`ifdef MEM_ALIGN_CHECK_EN
    assign mis_now = ~is_byte_op_i & (addr_i[1:0] != 2'b00);
`else
    assign mis_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = mis_now ? DONE : REQ;
            REQ:     if (req_ready_i) state_nx = resp_valid_i ? DONE : WAIT;
            WAIT:    if (resp_valid_i) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Response data is only taken when the request has been accepted.
    assign capture = resp_valid_i & ((state == REQ & req_ready_i) | state == WAIT);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            req_we_o    <= 1'b0;
            req_addr_o  <= '0;
            req_wdata_o <= '0;
            req_be_o    <= 4'h0;
            lane        <= 2'b00;
            is_byte     <= 1'b0;
            mis         <= 1'b0;
            rdata       <= '0;
        end else begin
            if (state == IDLE && start) begin
                req_we_o    <= is_store_op_i;
                req_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                req_wdata_o <= is_byte_op_i ? {4{store_data_i[7:0]}} : store_data_i;
                req_be_o    <= is_byte_op_i ? 4'b0001 << addr_i[1:0] : 4'hF;
                lane        <= addr_i[1:0];
                is_byte     <= is_byte_op_i;
                mis         <= mis_now;
                rdata       <= '0;
            end
            if (capture) rdata <= resp_rdata_i;
        end
    end

    assign rbyte        = rdata[{lane, 3'b000} +: 8];
    assign req_valid_o  = state == REQ;
    assign load_valid_o = state == DONE & ~req_we_o;
    assign load_data_o  = (load_valid_o & ~mis) ? (is_byte ? {24'b0, rbyte} : rdata) : 32'h0;
    assign misaligned_o = state == DONE & mis;
    assign stall_o      = start & (state != DONE);
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Expectations follow the MEM_ALIGN_CHECK_EN setting of the build.
module tb_mem_access_unit;
    logic        clk, n_reset;
    logic        op_valid, is_load, is_store, is_byte;
    logic [31:0] addr, store_data, load_data, req_addr, req_wdata, resp_rdata;
    logic        stall, load_valid, req_valid, req_ready, req_we, resp_valid, misaligned;
    logic [3:0]  req_be;
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .n_reset(n_reset), .op_valid_i(op_valid), .is_load_op_i(is_load),
        .is_store_op_i(is_store), .is_byte_op_i(is_byte), .addr_i(addr), .store_data_i(store_data),
        .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid), .req_valid_o(req_valid),
        .req_ready_i(req_ready), .req_we_o(req_we), .req_addr_o(req_addr), .req_wdata_o(req_wdata),
        .req_be_o(req_be), .resp_valid_i(resp_valid), .resp_rdata_i(resp_rdata), .misaligned_o(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        op_valid = 0; is_load = 0; is_store = 0; is_byte = 0;
        req_ready = 0; resp_valid = 0;
    endtask

    // Best-case load: ready and response both present in the first REQ cycle.
    task automatic run_load(input logic [31:0] a, input logic b, input logic [3:0] be,
                            input logic [31:0] rd, input logic [31:0] exp);
        op_valid = 1; is_load = 1; is_store = 0; is_byte = b; addr = a;
        req_ready = 1; resp_valid = 1; resp_rdata = rd;
        #1;
        check("ld_c0_stall", stall, 1);
        check("ld_c0_req_valid", req_valid, 0);
        tick;
        check("ld_c1_req_valid", req_valid, 1);
        check("ld_c1_stall", stall, 1);
        check("ld_req_addr", req_addr, {a[31:2], 2'b00});
        check("ld_req_be", req_be, be);
        check("ld_req_we", req_we, 0);
        tick;
        check("ld_done_stall", stall, 0);
        check("ld_done_valid", load_valid, 1);
        check("ld_done_data", load_data, exp);
        check("ld_done_misaligned", misaligned, 0);
        check("ld_done_req_valid", req_valid, 0);
        tick;
        idle_inputs;
        #1;
        check("ld_after_valid", load_valid, 0);
        check("ld_after_req_valid", req_valid, 0);
    endtask

    initial begin
        n_reset = 0; addr = 0; store_data = 0; resp_rdata = 0;
        idle_inputs;
        #2;
        check("rst_req_valid", req_valid, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_load_data", load_data, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_be", req_be, 0);
        check("rst_misaligned", misaligned, 0);
        tick; tick;
        n_reset = 1;
        tick;

        run_load(32'h100, 0, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF);
        run_load(32'h103, 1, 4'b1000, 32'h89ABCDEF, 32'h00000089);
        run_load(32'h100, 1, 4'b0001, 32'h89ABCDEF, 32'h000000EF);
        run_load(32'h101, 1, 4'b0010, 32'h89ABCDEF, 32'h000000CD);

        // SB with ready held off for three REQ cycles and response two cycles after acceptance.
        for (int c = 0; c < 8; c++) begin
            op_valid = 1; is_store = 1; is_load = 0; is_byte = 1;
            addr = 32'h102; store_data = 32'h12345678;
            req_ready = (c == 4); resp_valid = (c == 6);
            #1;
            check("sb_stall", stall, (c < 7));
            check("sb_req_valid", req_valid, (c >= 1 && c <= 4));
            check("sb_load_valid", load_valid, 0);
            if (c >= 1 && c <= 4) begin
                check("sb_be", req_be, 4'b0100);
                check("sb_wdata", req_wdata, 32'h78787878);
                check("sb_addr", req_addr, 32'h100);
                check("sb_we", req_we, 1);
            end
            tick;
        end
        idle_inputs;
        tick;

        // Spurious response in IDLE together with a memory op carrying no flag.
        for (int c = 0; c < 3; c++) begin
            op_valid = 1; resp_valid = 1; resp_rdata = 32'hCAFEF00D;
            #1;
            check("spur_req_valid", req_valid, 0);
            check("spur_stall", stall, 0);
            check("spur_load_valid", load_valid, 0);
            tick;
        end
        idle_inputs;
        tick;

        // Reset while waiting for the response.
        op_valid = 1; is_load = 1; addr = 32'h200; req_ready = 1; resp_valid = 0;
        tick;
        tick;
        n_reset = 0; op_valid = 0; is_load = 0; req_ready = 0;
        #1;
        check("wrst_req_valid", req_valid, 0);
        check("wrst_req_addr", req_addr, 0);
        check("wrst_req_be", req_be, 0);
        check("wrst_load_valid", load_valid, 0);
        check("wrst_stall", stall, 0);
        tick;
        n_reset = 1; resp_valid = 1; resp_rdata = 32'h55555555;
        #1;
        check("late_resp_valid", load_valid, 0);
        tick;
        check("late_resp_valid2", load_valid, 0);
        check("late_resp_req", req_valid, 0);
        resp_valid = 0;
        tick;
        run_load(32'h100, 0, 4'hF, 32'hA5A5A5A5, 32'hA5A5A5A5);

`ifdef MEM_ALIGN_CHECK_EN
        op_valid = 1; is_load = 1; is_byte = 0; addr = 32'h101;
        req_ready = 1; resp_valid = 1; resp_rdata = 32'h11223344;
        #1;
        check("mis_c0_stall", stall, 1);
        tick;
        check("mis_req_valid", req_valid, 0);
        check("mis_stall", stall, 0);
        check("mis_pulse", misaligned, 1);
        check("mis_load_valid", load_valid, 1);
        check("mis_load_data", load_data, 0);
        tick;
        idle_inputs;
        #1;
        check("mis_pulse_end", misaligned, 0);
        check("mis_req_after", req_valid, 0);
        tick;
`else
        run_load(32'h101, 0, 4'hF, 32'h11223344, 32'h11223344);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
